// File: rtl/vedic_mul_seq_ctrl.sv
// vedic_mul_seq_ctrl: 16x16 -> 32 multiply sequencer that time-shares one
// combinational 8x8 vedic core over four partial-product phases.
// Optional build macro: VEDIC_SIGNED_EN (two's complement operands via
// sign/magnitude; the sum is negated in the last phase when needed).
module vedic_mul_seq_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

  state_t           state;
  logic [15:0]      a_reg;
  logic [15:0]      b_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      acc_reg;

  logic [15:0]      accept_a;
  logic [15:0]      accept_b;
  logic [7:0]       op_x;
  logic [7:0]       op_y;
  logic [15:0]      core_out;
  logic [31:0]      term;
  logic [31:0]      sum_next;
  logic [31:0]      product_next;
  logic [7:0]       pp [4];

  // 2x2 Urdhva-Tiryagbhyam cell: vertical and crosswise bit products.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, t2, t3, c1;
    t0 = x[0] & y[0];
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, t0};
  endfunction

  // 4x4 vedic block from four 2x2 cells aligned by nibble-half weight.
  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  // 8x8 core: one 4x4 block per nibble pairing (gi[0] picks x nibble, gi[1] picks y nibble).
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    assign pp[gi] = vedic4(op_x[(gi % 2) * 4 +: 4], op_y[(gi / 2) * 4 +: 4]);
  end

  assign core_out = {8'b0, pp[0]} + {4'b0, pp[1], 4'b0} + {4'b0, pp[2], 4'b0} + {pp[3], 8'b0};

`ifdef VEDIC_SIGNED_EN
  logic neg_reg;
  // Magnitudes fit in 16 unsigned bits; -32768 maps to 0x8000.
  assign accept_a     = in_a[15] ? (~in_a + 16'd1) : in_a;
  assign accept_b     = in_b[15] ? (~in_b + 16'd1) : in_b;
  assign product_next = neg_reg ? (~sum_next + 32'd1) : sum_next;
`else
  assign accept_a     = in_a;
  assign accept_b     = in_b;
  assign product_next = sum_next;
`endif

  // Select which byte pair feeds the shared core in each phase.
  always_comb begin
    op_x = a_reg[7:0];
    op_y = b_reg[7:0];
    case (state)
      P1:      op_x = a_reg[15:8];
      P2:      op_y = b_reg[15:8];
      P3: begin
        op_x = a_reg[15:8];
        op_y = b_reg[15:8];
      end
      default: ;
    endcase
  end

  // Align the partial product to its byte weight; nothing is added outside the phases.
  always_comb begin
    term = '0;
    case (state)
      P0:      term = {16'b0, core_out};
      P1, P2:  term = {8'b0, core_out, 8'b0};
      P3:      term = {core_out, 16'b0};
      default: ;
    endcase
  end

  assign sum_next = acc_reg + term;

  // Ready in IDLE, or in DONE when the held result is being taken this cycle.
  assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));

  // Sequencer: accept, four accumulate phases, then hold the result until handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      tag_reg   <= '0;
      acc_reg   <= '0;
      product   <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_cnt    <= '0;
`ifdef VEDIC_SIGNED_EN
      neg_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= accept_a;
            b_reg   <= accept_b;
            tag_reg <= in_tag;
            acc_reg <= '0;
            busy    <= 1'b1;
            state   <= P0;
`ifdef VEDIC_SIGNED_EN
            neg_reg <= in_a[15] ^ in_b[15];
`endif
          end
        end
        P0: begin
          acc_reg <= sum_next;
          state   <= P1;
        end
        P1: begin
          acc_reg <= sum_next;
          state   <= P2;
        end
        P2: begin
          acc_reg <= sum_next;
          state   <= P3;
        end
        P3: begin
          acc_reg   <= sum_next;
          product   <= product_next;
          out_tag   <= tag_reg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            op_cnt    <= op_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg   <= accept_a;
              b_reg   <= accept_b;
              tag_reg <= in_tag;
              acc_reg <= '0;
              state   <= P0;
`ifdef VEDIC_SIGNED_EN
              neg_reg <= in_a[15] ^ in_b[15];
`endif
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// tb_vedic_mul_seq_ctrl: directed vectors with hand-computed products for
// vedic_mul_seq_ctrl. Honours VEDIC_SIGNED_EN the same way as the design.
module tb_vedic_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [3:0]  out_tag;
  logic        busy;
  logic [15:0] op_cnt;

  int vectors = 0;
  int miscompares = 0;

  vedic_mul_seq_ctrl #(.TAG_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .out_tag   (out_tag),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for its result; leaves the bench in DONE.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [31:0] exp);
    int n;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_tag = ~tag;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd4);
    check({name, "_product"}, product, exp);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    $display("op %s: a=0x%04h b=0x%04h tag=%0d -> product=0x%08h tag=%0d after %0d edges",
             name, a, b, tag, product, out_tag, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_ffff;
    logic [31:0] exp_q [3];
    logic [3:0]  tag_q [3];
    int t, last, k;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready_pre", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;

    // Basic product, latency and handoff count.
    out_ready = 1'b1;
    run_op("t1", 16'h1234, 16'h5678, 4'd3, 32'h06260060);
    @(posedge clk); #1;
    check("t1_op_cnt", 32'(op_cnt), 32'd1);
    check("t1_out_valid_drop", 32'(out_valid), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Extremes.
`ifdef VEDIC_SIGNED_EN
    exp_ffff = 32'h00000001;
`else
    exp_ffff = 32'hFFFE0001;
`endif
    run_op("t2_max", 16'hFFFF, 16'hFFFF, 4'd1, exp_ffff);
    @(posedge clk); #1;
    run_op("t2_zero", 16'h0000, 16'hABCD, 4'd2, 32'h00000000);
    @(posedge clk); #1;
    check("t2_op_cnt", 32'(op_cnt), 32'd3);

    // Backpressure: result must hold, and a pulsed request must be ignored.
    out_ready = 1'b0;
    run_op("t3", 16'h00FF, 16'h0101, 4'd5, 32'h0000FFFF);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7; in_tag = 4'd9;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t3_hold_product", product, 32'h0000FFFF);
      check("t3_hold_tag", 32'(out_tag), 32'd5);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("t3_op_cnt", 32'(op_cnt), 32'd4);
    check("t3_out_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_op_cnt_once", 32'(op_cnt), 32'd4);
    check("t3_no_ghost", 32'(out_valid), 32'd0);

    // Back-to-back with in_valid held high: results every 5 cycles, in order.
    exp_q[0] = 32'd15;       tag_q[0] = 4'd0;
    exp_q[1] = 32'h00010000; tag_q[1] = 4'd1;
    exp_q[2] = 32'h00017FFD; tag_q[2] = 4'd2;
    in_a = 16'd3; in_b = 16'd5; in_tag = 4'd0; in_valid = 1'b1;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_a = 16'h0100; in_b = 16'h0100; in_tag = 4'd1;
    t = 0; last = 0; k = 0;
    while (k < 3 && t < 40) begin
      @(posedge clk); #1;
      t++;
      if (out_valid) begin
        check("t4_interval", 32'(t - last), (k == 0) ? 32'd4 : 32'd5);
        check("t4_product", product, exp_q[k]);
        check("t4_tag", 32'(out_tag), 32'(tag_q[k]));
        $display("op t4[%0d]: product=0x%08h tag=%0d at edge %0d", k, product, out_tag, t);
        last = t;
        k++;
        if (k == 1) begin
          in_a = 16'h0100; in_b = 16'h0100; in_tag = 4'd1;
        end else if (k == 2) begin
          in_a = 16'h7FFF; in_b = 16'h0003; in_tag = 4'd2;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("t4_count", 32'(k), 32'd3);
    @(posedge clk); #1;
    check("t4_op_cnt", 32'(op_cnt), 32'd7);
    check("t4_idle", 32'(busy), 32'd0);

    // Reset during P2 aborts the operation.
    in_a = 16'h1111; in_b = 16'h2222; in_tag = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_op_cnt", 32'(op_cnt), 32'd0);
    check("t5_product", product, 32'd0);
    #1;
    run_op("t5_new", 16'd2, 16'd3, 4'd6, 32'd6);
    @(posedge clk); #1;
    check("t5_op_cnt_after", 32'(op_cnt), 32'd1);

    // Operand interpretation.
`ifdef VEDIC_SIGNED_EN
    run_op("t6_neg1x2", 16'hFFFF, 16'h0002, 4'd4, 32'hFFFFFFFE);
    @(posedge clk); #1;
    run_op("t6_minxmin", 16'h8000, 16'h8000, 4'd8, 32'h40000000);
    @(posedge clk); #1;
    run_op("t6_minxmax", 16'h8000, 16'h7FFF, 4'd10, 32'hC0008000);
    @(posedge clk); #1;
`else
    run_op("t6_unsigned", 16'hFFFF, 16'h0002, 4'd4, 32'h0001FFFE);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
